// File: rtl/hedios_probe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hedios_probe_pkg
// Description : Shared mode encodings and sizing constants for the Hedios
//               probe bank. HEDIOS_PROBE_OVF_EN adds the overflow-flag slot.
// Revision    : 1.0 - initial release
// ============================================================================
package hedios_probe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FREE  = 2'd1,
        MODE_EVENT = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    localparam int SLOT_W       = 32;
    localparam int MAX_CHANNELS = 16;

`ifdef HEDIOS_PROBE_OVF_EN
    localparam int OVF_SLOTS = 1;
`else
    localparam int OVF_SLOTS = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/hedios_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : hedios_prescaler
// Description : Free-running 0..PRESCALE-1 counter producing a registered
//               one-cycle tick. The first tick follows PRESCALE cycles after
//               reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module hedios_prescaler #(
    parameter int PRESCALE = 16_777_216
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter and registered tick; tick is high in the cycle after the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == LAST);
        end
    end

    assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/hedios_probe_bank.sv
`default_nettype none
// ============================================================================
// Module      : hedios_probe_bank
// Description : Multi-channel probe/counter bank. Each channel synchronises
//               its raw input lane and then passes it through, free-runs on
//               the shared prescaler tick, counts rising edges of lane bit 0,
//               or holds. Values are published into 32-bit slots, either live
//               or as a coherent snapshot when freeze is high.
//               Optional macro HEDIOS_PROBE_OVF_EN adds a sticky overflow
//               flag slot at index CHANNELS.
// Revision    : 1.0 - initial release
// ============================================================================
module hedios_probe_bank
    import hedios_probe_pkg::*;
#(
    parameter int   CHANNELS    = 5,
    parameter int   CNT_WIDTH   = 8,
    parameter int   PRESCALE    = 16_777_216,
    parameter int   SYNC_STAGES = 2,
    localparam int  SLOT_COUNT  = CHANNELS + OVF_SLOTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*CNT_WIDTH-1:0] ch_in,
    input  logic [2*CHANNELS-1:0]         ch_mode,
    input  logic [CHANNELS-1:0]           clear,
    input  logic                          freeze,
    input  logic                          snap_req,
    output logic                          snap_done,
    output logic                          tick,
    output logic [SLOT_W*SLOT_COUNT-1:0]  hedios_slots
);

    logic w_tick;
    logic slot_upd;
    logic snap_done_q;

`ifdef HEDIOS_PROBE_OVF_EN
    logic [CHANNELS-1:0] ovf_set;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] ovf_slot_q;
`endif

    hedios_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign tick     = w_tick;
    // Slots follow the channel values when live, or only on a snapshot request.
    assign slot_upd = ~freeze | snap_req;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] sync_q [SYNC_STAGES];
        logic                 edge_q;
        logic [CNT_WIDTH-1:0] v_q;
        logic [CNT_WIDTH-1:0] v_d;
        logic [CNT_WIDTH-1:0] slot_q;
        logic                 evt;
        logic                 inc;
        mode_e                mode;

        assign mode = mode_e'(ch_mode[2*i +: 2]);
        assign evt  = sync_q[SYNC_STAGES-1][0] & ~edge_q;

        // Synchroniser chain and edge register for the event source bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= '0;
                end
                edge_q <= 1'b0;
            end else begin
                sync_q[0] <= ch_in[i*CNT_WIDTH +: CNT_WIDTH];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
                edge_q <= sync_q[SYNC_STAGES-1][0];
            end
        end

        // Mode action for the value register; clear overrides any increment.
        always_comb begin
            inc = 1'b0;
            v_d = v_q;
            case (mode)
                MODE_PASS:  v_d = sync_q[SYNC_STAGES-1];
                MODE_FREE:  inc = w_tick;
                MODE_EVENT: inc = evt;
                default:    inc = 1'b0;
            endcase
            if (inc) begin
                v_d = v_q + CNT_WIDTH'(1);
            end
            if (clear[i]) begin
                v_d = '0;
            end
        end

        // Value and published slot registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= '0;
                slot_q <= '0;
            end else begin
                v_q <= v_d;
                if (slot_upd) begin
                    slot_q <= v_q;
                end
            end
        end

        assign hedios_slots[i*SLOT_W +: SLOT_W] = SLOT_W'(slot_q);

`ifdef HEDIOS_PROBE_OVF_EN
        // A wrap is an increment taken from the all-ones value.
        assign ovf_set[i] = inc & (&v_q);
`endif
    end

`ifdef HEDIOS_PROBE_OVF_EN
    // Sticky flags: set on wrap, clear wins over a same-cycle set.
    always_comb begin
        ovf_d = (ovf_q | ovf_set) & ~clear;
    end

    // Overflow flags and their slot, which follows the same freeze rules.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= '0;
            ovf_slot_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (slot_upd) begin
                ovf_slot_q <= ovf_q;
            end
        end
    end

    assign hedios_slots[CHANNELS*SLOT_W +: SLOT_W] = SLOT_W'(ovf_slot_q);
`endif

    // Snapshot acknowledge appears together with the freshly latched slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_done_q <= 1'b0;
        end else begin
            snap_done_q <= snap_req;
        end
    end

    assign snap_done = snap_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hedios_probe_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_hedios_probe_bank
// Description : Self-checking bench for hedios_probe_bank (3 channels, 8-bit
//               values, prescale 4). Expected values are queued when stimulus
//               is applied and popped when the DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hedios_probe_bank;

    localparam int CH = 3;
    localparam int CW = 8;
    localparam int PS = 4;
    localparam int SS = 2;
`ifdef HEDIOS_PROBE_OVF_EN
    localparam int NSLOT = CH + 1;
`else
    localparam int NSLOT = CH;
`endif

    localparam logic [1:0] M_PASS  = 2'd0;
    localparam logic [1:0] M_FREE  = 2'd1;
    localparam logic [1:0] M_EVENT = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [CH*CW-1:0]       ch_in = '0;
    logic [2*CH-1:0]        ch_mode = {CH{M_HOLD}};
    logic [CH-1:0]          clear = '0;
    logic                   freeze = 1'b0;
    logic                   snap_req = 1'b0;
    logic                   snap_done;
    logic                   tick;
    logic [32*NSLOT-1:0]    hedios_slots;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    logic [31:0] got;

    hedios_probe_bank #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .PRESCALE    (PS),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_in        (ch_in),
        .ch_mode      (ch_mode),
        .clear        (clear),
        .freeze       (freeze),
        .snap_req     (snap_req),
        .snap_done    (snap_done),
        .tick         (tick),
        .hedios_slots (hedios_slots)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return hedios_slots[i*32 +: 32];
    endfunction

    task automatic set_mode(input int c, input logic [1:0] m);
        ch_mode[2*c +: 2] = m;
    endtask

    task automatic set_lane(input int c, input logic [CW-1:0] val);
        ch_in[c*CW +: CW] = val;
    endtask

    // Advance until the tick output is seen high; the increment it causes lands on the next edge.
    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 4*PS) begin
            step(1);
            k++;
        end
        if (tick !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: tick=%b required 1 within %0d cycles", tick, 4*PS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        set_mode(0, M_PASS);
        set_lane(0, 8'h5A);
        snap_req = 1'b1;
        exp_q.push_back(32'h0000_005A);
        step(5);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_pre_activity: slot0=%h required %h", got, exp); end

        rst = 1'b1;
        for (int i = 0; i < NSLOT; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        step(3);
        for (int i = 0; i < NSLOT; i++) begin
            exp = exp_q.pop_front(); got = slot(i); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_slot%0d: got %h required %h", i, got, exp); end
        end
        exp = exp_q.pop_front(); got = {31'h0, tick}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_tick: got %h required %h", got, exp); end
        exp = exp_q.pop_front(); got = {31'h0, snap_done}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_snap_done: got %h required %h", got, exp); end

        rst = 1'b0;
        snap_req = 1'b0;
        ch_mode = {CH{M_HOLD}};
        ch_in = '0;
        for (int k = 1; k <= PS; k++) exp_q.push_back((k == PS) ? 32'h1 : 32'h0);
        for (int k = 1; k <= PS; k++) begin
            step(1);
            exp = exp_q.pop_front(); got = {31'h0, tick}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL first_tick_cycle%0d: tick=%h required %h", k, got, exp); end
        end
    endtask

    task automatic test_pass();
        set_mode(0, M_PASS);
        set_lane(0, 8'hA5);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_00A5);
        step(3);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL pass_edge3: slot0=%h required %h", got, exp); end
        step(1);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL pass_edge4: slot0=%h required %h", got, exp); end
    endtask

    task automatic test_free();
        set_mode(1, M_PASS);
        set_lane(1, 8'hFE);
        exp_q.push_back(32'h0000_00FE);
        step(4);
        exp = exp_q.pop_front(); got = slot(1); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL free_load: slot1=%h required %h", got, exp); end
        set_mode(1, M_FREE);
        exp_q.push_back(32'h0000_00FF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            step(2);
            exp = exp_q.pop_front(); got = slot(1); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL free_tick%0d: slot1=%h required %h", t, got, exp); end
`ifdef HEDIOS_PROBE_OVF_EN
            if (t == 1) begin
                n_tests++; got = slot(CH);
                if (got !== 32'h2) begin n_fail++; $display("FAIL ovf_set: ovf=%h required %h", got, 32'h2); end
            end
`endif
        end
        clear[1] = 1'b1;
        exp_q.push_back(32'h0);
        step(1);
        clear[1] = 1'b0;
        step(1);
        exp = exp_q.pop_front(); got = slot(1); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL free_clear: slot1=%h required %h", got, exp); end
`ifdef HEDIOS_PROBE_OVF_EN
        n_tests++; got = slot(CH);
        if (got !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: ovf=%h required %h", got, 32'h0); end
`endif
        set_mode(1, M_HOLD);
    endtask

    task automatic test_event();
        set_mode(2, M_EVENT);
        exp_q.push_back(32'h5);
        for (int e = 0; e < 5; e++) begin
            ch_in[16] = 1'b1;
            step(2);
            ch_in[16] = 1'b0;
            step(2);
        end
        step(4);
        exp = exp_q.pop_front(); got = slot(2); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL event_count: slot2=%h required %h", got, exp); end

        ch_in[16] = 1'b1;
        exp_q.push_back(32'h0);
        step(2);
        clear[2] = 1'b1;
        step(1);
        clear[2] = 1'b0;
        step(2);
        exp = exp_q.pop_front(); got = slot(2); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL event_clear_coincident: slot2=%h required %h", got, exp); end
        ch_in[16] = 1'b0;
        step(4);
    endtask

    task automatic test_freeze();
        clear[1] = 1'b1;
        set_mode(1, M_FREE);
        freeze = 1'b1;
        set_lane(0, 8'h3C);
        step(1);
        clear[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_tick();
            step(1);
        end
        exp_q.push_back(32'h0000_00A5);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL freeze_hold0: slot0=%h required %h", got, exp); end
        exp = exp_q.pop_front(); got = slot(1); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL freeze_hold1: slot1=%h required %h", got, exp); end

        snap_req = 1'b1;
        exp_q.push_back(32'h0000_003C);
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        step(1);
        snap_req = 1'b0;
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL snap_slot0: slot0=%h required %h", got, exp); end
        exp = exp_q.pop_front(); got = slot(1); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL snap_slot1: slot1=%h required %h", got, exp); end
        exp = exp_q.pop_front(); got = {31'h0, snap_done}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL snap_done_pulse: got %h required %h", got, exp); end
        step(1);
        exp = exp_q.pop_front(); got = {31'h0, snap_done}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL snap_done_single: got %h required %h", got, exp); end

        freeze = 1'b0;
        exp_q.push_back(32'h0000_0003);
        wait_tick();
        step(2);
        exp = exp_q.pop_front(); got = slot(1); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL unfreeze_live: slot1=%h required %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        freeze = 1'b1;
        snap_req = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            exp = exp_q.pop_front(); got = {31'h0, snap_done}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b_snap_done%0d: got %h required %h", k, got, exp); end
        end
        snap_req = 1'b0;
        step(1);
        exp = exp_q.pop_front(); got = {31'h0, snap_done}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_snap_done_end: got %h required %h", got, exp); end
        freeze = 1'b0;
        set_mode(1, M_HOLD);
    endtask

    task automatic test_hold();
        set_mode(0, M_PASS);
        set_lane(0, 8'h10);
        exp_q.push_back(32'h0000_0010);
        step(4);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL hold_load: slot0=%h required %h", got, exp); end
        wait_tick();
        step(1);
        set_mode(0, M_FREE);
        step(1);
        set_mode(0, M_HOLD);
        exp_q.push_back(32'h0000_0010);
        step(20);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL hold_steady: slot0=%h required %h", got, exp); end
        set_mode(0, M_FREE);
        exp_q.push_back(32'h0000_0011);
        wait_tick();
        step(2);
        exp = exp_q.pop_front(); got = slot(0); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL hold_resume: slot0=%h required %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_free();
        test_event();
        test_freeze();
        test_back_to_back();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
